dmem_arbiter: RTL

Single-port access controller placed between the single-cycle core, a DMA/debug requester, and the 100-word data memory. After reset it zero-fills the memory array, since the array itself has no content reset. It then shares the one memory port: the core gets same-cycle priority, and the DMA port gets a bounded-wait fairness slot. Memory reads are combinational; memory writes commit on the rising clock edge.

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arbiter_wait_counter.sv | 34 +++
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_pkg: shared types and defaults for the dmem arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dmem_arbiter_pkg;

  localparam int c_DEPTH_DEFAULT    = 100;
  localparam int c_DATA_W_DEFAULT   = 32;
  localparam int c_ADDR_W_DEFAULT   = 32;
  localparam int c_MAX_WAIT_DEFAULT = 4;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_if: core, DMA and memory-port bundle of the arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT,
  parameter int ADDR_W = c_ADDR_W_DEFAULT
) ();

  logic              cpu_en;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              init_done;

  modport slave (
    input  cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output init_done
  );

  modport master (
    output cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  init_done
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_wait_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter_wait_counter: saturating DMA denial counter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dmem_arbiter_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_inc,
  input  wire logic i_clr,
  output logic      o_sat
);

  localparam int c_CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_WAIT);

  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_arbiter: zero-fills data memory, then shares its single port |
// | between the core (priority) and DMA (bounded wait). Rev 1.0      |
// +------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH    = c_DEPTH_DEFAULT,
  parameter int DATA_W   = c_DATA_W_DEFAULT,
  parameter int ADDR_W   = c_ADDR_W_DEFAULT,
  parameter int MAX_WAIT = c_MAX_WAIT_DEFAULT
) (
  input wire logic      clk,
  input wire logic      rst,
  dmem_arbiter_if.slave bus
);

  localparam int                c_CLR_W   = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [c_CLR_W-1:0] c_LAST   = c_CLR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  c_DEPTH_A = ADDR_W'(DEPTH);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CLR_W-1:0]  r_clr_cnt;
  logic                r_init_done;

  owner_t              w_owner;
  logic                w_cpu_stall;
  logic                w_dma_gnt;
  logic                w_wait_inc;
  logic                w_wait_clr;
  logic                w_wait_sat;
  logic                w_clr_wr;

  logic                w_cpu_in_range;
  logic                w_dma_in_range;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  logic                r_dma_rvalid;
  logic                r_dma_err;
  logic [DATA_W-1:0]   r_dma_rdata;

  assign w_cpu_in_range = (bus.cpu_addr < c_DEPTH_A);
  assign w_dma_in_range = (bus.dma_addr < c_DEPTH_A);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave CLEAR once the last word has been written
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && (r_clr_cnt == c_LAST)) begin
      w_state_nxt = READY;
    end
  end

  // Output logic: port ownership and handshakes
  always_comb begin
    w_owner     = OWN_NONE;
    w_cpu_stall = 1'b0;
    w_dma_gnt   = 1'b0;
    w_wait_inc  = 1'b0;
    w_wait_clr  = 1'b0;
    w_clr_wr    = 1'b0;
    if (rst) begin
      w_cpu_stall = 1'b1;
    end else if (r_state == CLEAR) begin
      w_cpu_stall = 1'b1;
      w_clr_wr    = 1'b1;
    end else if (bus.dma_req && w_wait_sat) begin
      w_owner     = OWN_DMA;
      w_cpu_stall = bus.cpu_en;
      w_dma_gnt   = 1'b1;
      w_wait_clr  = 1'b1;
    end else if (bus.cpu_en) begin
      w_owner     = OWN_CPU;
      w_wait_inc  = bus.dma_req;
    end else if (bus.dma_req) begin
      w_owner     = OWN_DMA;
      w_dma_gnt   = 1'b1;
      w_wait_clr  = 1'b1;
    end else begin
      w_wait_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == CLEAR) begin
      if (r_clr_cnt == c_LAST) begin
        r_clr_cnt   <= '0;
        r_init_done <= 1'b1;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  dmem_arbiter_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wait_inc),
    .i_clr (w_wait_clr),
    .o_sat (w_wait_sat)
  );

  // Memory port mux; out-of-range writes never reach the array
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    unique case (w_owner)
      OWN_CPU: begin
        w_mem_we    = bus.cpu_we && w_cpu_in_range;
        w_mem_addr  = bus.cpu_addr;
        w_mem_wdata = bus.cpu_wdata;
      end
      OWN_DMA: begin
        w_mem_we    = bus.dma_we && w_dma_in_range;
        w_mem_addr  = bus.dma_addr;
        w_mem_wdata = bus.dma_wdata;
      end
      default: begin
        if (w_clr_wr) begin
          w_mem_we   = 1'b1;
          w_mem_addr = ADDR_W'(r_clr_cnt);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dma_rvalid <= 1'b0;
      r_dma_err    <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_dma_rvalid <= w_dma_gnt && !bus.dma_we;
      r_dma_err    <= w_dma_gnt && !w_dma_in_range;
      if (w_dma_gnt && !bus.dma_we) begin
        r_dma_rdata <= w_dma_in_range ? bus.mem_rdata : '0;
      end
    end
  end

  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.cpu_rdata  = ((w_owner == OWN_CPU) && w_cpu_in_range) ? bus.mem_rdata : '0;
  assign bus.cpu_stall  = w_cpu_stall;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.dma_rvalid = r_dma_rvalid;
  assign bus.dma_err    = r_dma_err;
  assign bus.dma_rdata  = r_dma_rdata;
  assign bus.init_done  = r_init_done;

endmodule
`default_nettype wire
